// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared constants and helper functions for the multi-channel accumulator.
//   ch_width(nch) : width of a channel index, never less than 1 bit
//   sat_max(w)    : largest signed value of a w-bit word (zero-extended to 64)
//   sat_min(w)    : smallest signed value of a w-bit word (caller truncates)
// -----------------------------------------------------------------------------
package accum_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_ACC_WIDTH = 64;

    function automatic int ch_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Inverting the maximum gives 1 followed by zeros in the low 'width' bits.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/accum_sat_add.sv
// -----------------------------------------------------------------------------
// accum_sat_add
// Signed add of a running sum and a sign-extended sample, with optional
// saturation and a sticky overflow flag. The result is available both
// combinationally (for accumulator write-back) and registered (as the output).
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : capture the new sum into the output register
//   acc_i       : running sum (already zeroed by the caller on a first sample)
//   add_i       : sign-extended sample
//   ovf_i       : sticky overflow carried with acc_i
//   sum_nxt_o   : combinational sum (saturated or wrapped)
//   ovf_nxt_o   : combinational sticky overflow
//   sum_o/ovf_o : registered copies of the above
// -----------------------------------------------------------------------------
module accum_sat_add
    import accum_pkg::*;
#(
    parameter int ACC_WIDTH = 48,
    parameter int SAT_MODE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [ACC_WIDTH-1:0] add_i,
    input  logic                 ovf_i,
    output logic [ACC_WIDTH-1:0] sum_nxt_o,
    output logic                 ovf_nxt_o,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    localparam logic [ACC_WIDTH-1:0] MAX_VAL = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] MIN_VAL = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic [ACC_WIDTH:0] wide_sum;
    logic               overflow;

    // One guard bit: the two top bits disagree exactly when the signed sum
    // left the ACC_WIDTH range; the guard bit then holds the true sign.
    assign wide_sum  = {acc_i[ACC_WIDTH-1], acc_i} + {add_i[ACC_WIDTH-1], add_i};
    assign overflow  = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
    assign ovf_nxt_o = ovf_i | overflow;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sum_nxt_o = wide_sum[ACC_WIDTH-1:0];
        if (overflow && (SAT_MODE != 0)) begin
            sum_nxt_o = wide_sum[ACC_WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_o <= '0;
            ovf_o <= 1'b0;
        end else if (en_i) begin
            sum_o <= sum_nxt_o;
            ovf_o <= ovf_nxt_o;
        end
    end

endmodule

// File: rtl/accumulator_mc.sv
// -----------------------------------------------------------------------------
// accumulator_mc
// Time-interleaved multi-channel integrate-and-dump. Samples arrive in channel
// order 0..NCH-1; after len_active complete sample periods each channel's sum
// is emitted, two cycles after its final sample was accepted.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous frame abort (wins over valid_in)
//   length      : samples per channel per dump (0 behaves as 1)
//   valid_in, ch_in, data_in : sample stream
//   valid_out, ch_out, data_out, ovf_out, last_out : one dumped channel sum
//   seq_err     : one-cycle pulse after an out-of-order channel tag
// -----------------------------------------------------------------------------
module accumulator_mc
    import accum_pkg::*;
#(
    parameter int LEN_WIDTH  = 18,
    parameter int DATA_WIDTH = 30,
    parameter int ACC_WIDTH  = 48,
    parameter int NCH        = 8,
    parameter int SAT_MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [LEN_WIDTH-1:0]    length,
    input  logic                    valid_in,
    input  logic [ch_width(NCH)-1:0] ch_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    valid_out,
    output logic [ch_width(NCH)-1:0] ch_out,
    output logic [ACC_WIDTH-1:0]    data_out,
    output logic                    ovf_out,
    output logic                    last_out,
    output logic                    seq_err
);

    localparam int                   CHW     = ch_width(NCH);
    localparam logic [CHW-1:0]       LAST_CH = CHW'(NCH - 1);
    localparam logic [CHW-1:0]       CH_ONE  = CHW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    // Frame control state
    logic [CHW-1:0]       exp_ch_q, exp_ch_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 len_load_q;   // length not yet sampled since reset
    logic                 seq_err_q;

    // Stage 1: accepted sample and its position within the frame
    logic                 s1_valid_q;
    logic [CHW-1:0]       s1_ch_q;
    logic [ACC_WIDTH-1:0] s1_data_q;
    logic                 s1_first_q;
    logic                 s1_emit_q;
    logic                 s1_frame_end_q;

    // Stage 2: output qualifiers (data/ovf live in accum_sat_add)
    logic                 valid_out_q;
    logic [CHW-1:0]       ch_out_q;
    logic                 last_out_q;

    // Per-channel storage
    logic [ACC_WIDTH-1:0] acc_mem [NCH];
    logic [NCH-1:0]       ovf_q;

    logic [LEN_WIDTH-1:0] len_in, cnt_base, len_base;
    logic                 ch_match, mismatch, abort, accept;
    logic                 first_smp, last_smp, period_end;
    logic [ACC_WIDTH-1:0] acc_op, sum_nxt;
    logic                 ovf_op, ovf_nxt;

    assign len_in   = (length == '0) ? LEN_ONE : length;
    assign ch_match = (ch_in == exp_ch_q);
    assign mismatch = valid_in && !clr && !ch_match;
    assign abort    = clr || mismatch;
    // A misordered channel-0 sample restarts the frame instead of being lost.
    assign accept   = valid_in && !clr && (ch_match || (ch_in == '0));

    // Frame position the current sample is judged against: an abort in this
    // cycle means the sample (if accepted) opens a brand-new frame.
    assign cnt_base   = abort ? '0 : cnt_q;
    assign len_base   = (abort || len_load_q) ? len_in : len_q;
    assign first_smp  = (cnt_base == '0);
    assign last_smp   = (cnt_base == len_base - LEN_ONE);
    assign period_end = (ch_in == LAST_CH);

    always_comb begin
        exp_ch_d = abort ? '0 : exp_ch_q;
        cnt_d    = cnt_base;
        len_d    = len_base;
        if (accept) begin
            if (period_end) begin
                exp_ch_d = '0;
                cnt_d    = last_smp ? '0 : cnt_base + LEN_ONE;
                if (last_smp) begin
                    len_d = len_in;
                end
            end else begin
                exp_ch_d = ch_in + CH_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ch_q       <= '0;
            cnt_q          <= '0;
            len_q          <= '0;
            len_load_q     <= 1'b1;
            seq_err_q      <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_ch_q        <= '0;
            s1_data_q      <= '0;
            s1_first_q     <= 1'b0;
            s1_emit_q      <= 1'b0;
            s1_frame_end_q <= 1'b0;
            valid_out_q    <= 1'b0;
            ch_out_q       <= '0;
            last_out_q     <= 1'b0;
        end else begin
            exp_ch_q   <= exp_ch_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            len_load_q <= 1'b0;
            seq_err_q  <= mismatch;

            // clr does not touch stage 1/2: sums already in flight complete.
            s1_valid_q <= accept;
            if (accept) begin
                s1_ch_q        <= ch_in;
                s1_data_q      <= {{(ACC_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
                s1_first_q     <= first_smp;
                s1_emit_q      <= last_smp;
                s1_frame_end_q <= last_smp && period_end;
            end

            valid_out_q <= s1_valid_q && s1_emit_q;
            last_out_q  <= s1_valid_q && s1_frame_end_q;
            if (s1_valid_q) begin
                ch_out_q <= s1_ch_q;
            end
        end
    end

    // NOTE: the accumulator array has no reset; the first sample of every
    // frame overwrites its entry, so its power-up contents are never read.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            acc_mem[s1_ch_q] <= sum_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (s1_valid_q) begin
            ovf_q[s1_ch_q] <= ovf_nxt;
        end
    end

    // A first sample ignores the stale sum and the stale sticky flag.
    assign acc_op = s1_first_q ? '0 : acc_mem[s1_ch_q];
    assign ovf_op = s1_first_q ? 1'b0 : ovf_q[s1_ch_q];

    accum_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SAT_MODE  (SAT_MODE)
    ) u_add (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (s1_valid_q),
        .acc_i     (acc_op),
        .add_i     (s1_data_q),
        .ovf_i     (ovf_op),
        .sum_nxt_o (sum_nxt),
        .ovf_nxt_o (ovf_nxt),
        .sum_o     (data_out),
        .ovf_o     (ovf_out)
    );

    assign valid_out = valid_out_q;
    assign ch_out    = ch_out_q;
    assign last_out  = last_out_q;
    assign seq_err   = seq_err_q;

endmodule

// File: doc/accumulator_mc.md
ACCUMULATOR_MC -- requirements
Module: accumulator_mc

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 18, width of accumulation-length input.
REQ-002 SHALL have parameter DATA_WIDTH, default 30, width of signed input sample.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, width of signed accumulator and output; legal range DATA_WIDTH+1..64.
REQ-004 SHALL have parameter NCH, default 8, number of time-interleaved channels; legal range 1..64.
REQ-005 SHALL have parameter SAT_MODE, default 1, where 1 means saturate on overflow and 0 means two's-complement wrap.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port clr  input  1  synchronous frame abort; clears accumulators and counters.
REQ-009 SHALL have port length  input  LEN_WIDTH  samples per channel per dump; 0 treated as 1.
REQ-010 SHALL have port valid_in  input  1  input sample qualifier.
REQ-011 SHALL have port ch_in  input  clog2(NCH) (min 1)  channel tag of data_in.
REQ-012 SHALL have port data_in  input  DATA_WIDTH  signed sample.
REQ-013 SHALL have port valid_out  output  1  one-cycle qualifier per dumped channel sum.
REQ-014 SHALL have port ch_out  output  clog2(NCH)  channel of data_out.
REQ-015 SHALL have port data_out  output  ACC_WIDTH  signed channel sum.
REQ-016 SHALL have port ovf_out  output  1  overflow/saturation occurred in this sum; qualified by valid_out.
REQ-017 SHALL have port last_out  output  1  high with valid_out for channel NCH-1 (frame end).
REQ-018 SHALL have port seq_err  output  1  one-cycle pulse on channel-order violation.

Function
REQ-019 Input SHALL arrive in channel order 0..NCH-1 repeating; a "sample period" completes on accepted ch_in==NCH-1.
REQ-020 Sample counter SHALL increment per completed sample period and wrap to 0 after reaching len_active-1.
REQ-021 len_active SHALL be loaded from length (0 mapped to 1) only at reset, clr, or frame end; mid-frame changes of length SHALL have no effect until next frame.
REQ-022 For each accepted sample on channel c: if sample counter==0, acc[c] <= sext(data_in), else acc[c] <= acc[c]+sext(data_in).
REQ-023 When sample counter==len_active-1, the channel's final sum SHALL be emitted and acc[c] need not be cleared (next write overwrites per REQ-022).
REQ-024 Output latency SHALL be exactly 2 cycles from the accepted final-sample beat to valid_out; ch_out, data_out, ovf_out, last_out aligned with valid_out.
REQ-025 SAT_MODE=1: sum SHALL clamp to max/min signed ACC_WIDTH value; SAT_MODE=0: sum SHALL wrap; either way per-channel sticky ovf bit SHALL set and be reported with that channel's sum, then cleared.
REQ-026 If valid_in and ch_in != expected channel: seq_err SHALL pulse 1 cycle later, frame SHALL abort as per clr; the offending sample SHALL be accepted as a new frame's first sample only if ch_in==0, otherwise discarded.
REQ-027 clr SHALL take priority over valid_in in the same cycle; the sample is discarded; pipeline outputs already in flight SHALL still be delivered.
REQ-028 Gaps (valid_in low) SHALL not advance any counter; no output backpressure exists.
REQ-029 With len_active==1 every accepted sample SHALL produce an output equal to sext(data_in).

Reset
REQ-030 rst_n low SHALL asynchronously clear counters, expected channel, ovf bits, pipeline valids, and all outputs to 0; len_active to max(length,1) on first clock after release.
REQ-031 Accumulator storage SHALL not require reset (REQ-022 overwrite semantics).

Structure
REQ-032 Constants (channel-index width function, SAT limits) SHALL live in shared package accum_pkg.
REQ-033 Per-channel add/saturate datapath SHALL be sub-module accum_sat_add (ACC_WIDTH, SAT_MODE), registered output.

Verification
REQ-034 NCH=4, length=3, data_in=ch+1 constant -> outputs ch0..3 = 3,6,9,12 every 12 beats, last_out on ch3, latency 2.
REQ-035 SAT_MODE=1, ACC_WIDTH=32, DATA_WIDTH=30, data=2^29-1, length=8 -> data_out=2^31-1, ovf_out=1; next frame data=1 -> 8, ovf_out=0.
REQ-036 length changed 3->5 mid-frame -> current frame dumps after 3, next after 5.
REQ-037 sequence ch 0,1,3 -> seq_err pulse, no output; resume 0..3 -> fresh sums correct.
REQ-038 clr asserted with valid_in mid-frame and rst_n pulsed mid-output -> no stale sums, outputs 0 during reset.
REQ-039 length=0, random valid gaps -> every sample echoed sign-extended, ch_out matches ch_in.
